// File: rtl/bk_pkg.sv
// Shared definitions for the digit-serial Brent-Kung adder/subtractor.
// Contents: digit width, sequencer state encoding, digit-count helper.
// Used by: bk_serial_adder.
package bk_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bk_ser_state_e;

  // Number of 4-bit digits in an operand of the given width.
  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/Brent_Kung_adder_4bit.sv
// Purpose: 4-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
// Latency: purely combinational, zero cycles.
// Ports: a_i, b_i (4-bit operands), cin_i (carry-in) -> sum_o (4-bit), cout_o.
module Brent_Kung_adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_g10, w_p10;
  logic       w_g32, w_p32;
  logic       w_g30, w_p30;
  logic [4:0] w_c;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  // Up-sweep: pairwise group generate/propagate, then the full 4-bit group.
  assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
  assign w_p10 = w_p[1] & w_p[0];
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];
  assign w_g30 = w_g32 | (w_p32 & w_g10);
  assign w_p30 = w_p32 & w_p10;

  // Down-sweep: fill in the odd-position carries from the group terms.
  assign w_c[0] = cin_i;
  assign w_c[1] = w_g[0] | (w_p[0] & cin_i);
  assign w_c[2] = w_g10 | (w_p10 & cin_i);
  assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);
  assign w_c[4] = w_g30 | (w_p30 & cin_i);

  assign sum_o  = w_p ^ w_c[3:0];
  assign cout_o = w_c[4];

endmodule

// File: rtl/bk_serial_adder.sv
// Purpose: digit-serial WIDTH-bit adder/subtractor; one nibble per cycle, LSB first,
//   through a single Brent_Kung_adder_4bit, carry held in a register between nibbles.
// Ports: clk_i, rst_i (sync, active-high); request valid_i/ready_o with a_i, b_i,
//   carry_i, sub_i; result valid_o/ready_i with sum_o, carry_o [, overflow_o].
// Latency: accept at edge k -> valid_o high after edge k+NIBBLES; result held until ready_i.
// Option: define BK_SERIAL_OVF_EN to add the registered signed-overflow output overflow_o.
module bk_serial_adder
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef BK_SERIAL_OVF_EN
  output logic             overflow_o,
`endif
  output logic             carry_o
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int CNT_W   = $clog2(NIBBLES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("bk_serial_adder: WIDTH must be a positive multiple of 4");
  end

  bk_ser_state_e r_state;
  bk_ser_state_e w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_carry_out;

  logic [NIBBLE_W-1:0]       w_nib;
  logic                      w_cout;
  logic                      w_last;
  logic [WIDTH+NIBBLE_W-1:0] w_sum_cat;
  logic [WIDTH-1:0]          w_sum_shift;

  Brent_Kung_adder_4bit u_bk4 (
    .a_i    (r_a[NIBBLE_W-1:0]),
    .b_i    (r_b[NIBBLE_W-1:0]),
    .cin_i  (r_carry),
    .sum_o  (w_nib),
    .cout_o (w_cout)
  );

  assign w_last = (r_cnt == LAST_CNT);

  // New nibble enters at the MSB end; after NIBBLES shifts the first one sits at bit 0.
  // Built via a widened concat so the expression is legal even when WIDTH == 4.
  assign w_sum_cat   = {w_nib, r_sum} >> NIBBLE_W;
  assign w_sum_shift = w_sum_cat[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_state_nxt = RUN;
      RUN:     if (w_last)  w_state_nxt = DONE;
      DONE:    if (ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_out   <= '0;
      r_carry_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            // Subtract is A + ~B + 1: invert B once here, force the carry-in.
            r_a     <= a_i;
            r_b     <= sub_i ? ~b_i : b_i;
            r_carry <= sub_i ? 1'b1 : carry_i;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          r_sum   <= w_sum_shift;
          // Visible outputs change only when the result is complete.
          if (w_last) begin
            r_sum_out   <= w_sum_shift;
            r_carry_out <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BK_SERIAL_OVF_EN
  logic r_ovf;

  // Carry into the MSB recovered from the top bit's sum: a ^ b ^ s = c_in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_a[NIBBLE_W-1] ^ r_b[NIBBLE_W-1] ^ w_nib[NIBBLE_W-1]) ^ w_cout;
    end
  end

  assign overflow_o = r_ovf;
`endif

  assign ready_o = (r_state == IDLE);
  assign valid_o = (r_state == DONE);
  assign sum_o   = r_sum_out;
  assign carry_o = r_carry_out;

endmodule

// File: tb/tb_bk_serial_adder.sv
// Bench for bk_serial_adder at WIDTH=16: directed operations with literal expectations
// plus an arithmetic reference model checked against the outputs every cycle.
// Define BK_SERIAL_OVF_EN for both bench and RTL to cover overflow_o.
module tb_bk_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         carry_i;
  logic         sub_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;
`ifdef BK_SERIAL_OVF_EN
  logic         overflow_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bk_serial_adder #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .carry_i    (carry_i),
    .sub_i      (sub_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
`ifdef BK_SERIAL_OVF_EN
    .overflow_o (overflow_o),
`endif
    .carry_o    (carry_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase = -1 when idle, else edges since accept.
  // Result visible once phase reaches N; held afterwards until replaced.
  int           m_phase = -1;
  logic [W-1:0] m_pend_sum;
  logic         m_pend_c;
  logic         m_pend_o;
  logic [W-1:0] m_sum = '0;
  logic         m_c = 1'b0;
  logic         m_o = 1'b0;

  always @(posedge clk_i) begin
    logic [W:0]   t;
    logic [W-1:0] bb;
    if (rst_i) begin
      m_phase = -1;
      m_sum = '0;
      m_c = 1'b0;
      m_o = 1'b0;
    end else if (m_phase < 0) begin
      if (valid_i) begin
        bb = sub_i ? ~b_i : b_i;
        t = {1'b0, a_i} + {1'b0, bb} + ((sub_i ? 1'b1 : carry_i) ? 17'd1 : 17'd0);
        m_pend_sum = t[W-1:0];
        m_pend_c   = t[W];
        m_pend_o   = (a_i[W-1] == bb[W-1]) && (t[W-1] != a_i[W-1]);
        m_phase = 0;
      end
    end else if (m_phase >= N) begin
      if (ready_i) m_phase = -1;
    end else begin
      m_phase++;
      if (m_phase == N) begin
        m_sum = m_pend_sum;
        m_c = m_pend_c;
        m_o = m_pend_o;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("mdl_ready", {31'b0, ready_o}, {31'b0, (m_phase < 0)});
      chk("mdl_valid", {31'b0, valid_o}, {31'b0, (m_phase >= N)});
      chk("mdl_sum", {16'b0, sum_o}, {16'b0, m_sum});
      chk("mdl_carry", {31'b0, carry_o}, {31'b0, m_c});
`ifdef BK_SERIAL_OVF_EN
      chk("mdl_ovf", {31'b0, overflow_o}, {31'b0, m_o});
`endif
    end
  end

  // One operation with downstream ready: literal result and latency checks.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int e;
    @(negedge clk_i);
    a_i = a; b_i = b; carry_i = c; sub_i = s; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    e = 0;
    while (!valid_o && e < 20) begin
      @(posedge clk_i);
      e++;
      @(negedge clk_i);
    end
    chk({nm, "_lat"}, e, N);
    chk({nm, "_sum"}, {16'b0, sum_o}, {16'b0, es});
    chk({nm, "_c"}, {31'b0, carry_o}, {31'b0, ec});
`ifdef BK_SERIAL_OVF_EN
    chk({nm, "_ovf"}, {31'b0, overflow_o}, {31'b0, eo});
`else
    if (eo === 1'bx) $display("unexpected X");
`endif
    @(posedge clk_i);
    @(negedge clk_i);
    chk({nm, "_idle"}, {31'b0, ready_o}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] hs;
    logic         hc;
    int           e;
    rst_i = 1'b1; valid_i = 1'b0; a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_sum", {16'b0, sum_o}, 32'd0);
    chk("rst_carry", {31'b0, carry_o}, 32'd0);
    rst_i = 1'b0;

    do_op("add",    16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    do_op("chain",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("cin",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("sub_neg",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("ovf_add",16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_sub",16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("add2",   16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);

    // Backpressure: hold result for 10 cycles; a new request in DONE is ignored.
    @(negedge clk_i);
    a_i = 16'h0100; b_i = 16'h0023; carry_i = 1'b0; sub_i = 1'b0; valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    e = 0;
    while (!valid_o && e < 20) begin
      @(posedge clk_i);
      e++;
      @(negedge clk_i);
    end
    chk("bp_lat", e, N);
    hs = sum_o; hc = carry_o;
    chk("bp_sum", {16'b0, hs}, 32'h0123);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a_i = 16'hAAAA; b_i = 16'h5555; valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      chk("bp_hold_valid", {31'b0, valid_o}, 32'd1);
      chk("bp_hold_ready", {31'b0, ready_o}, 32'd0);
      chk("bp_hold_sum", {16'b0, sum_o}, {16'b0, hs});
      chk("bp_hold_c", {31'b0, carry_o}, {31'b0, hc});
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("bp_release_ready", {31'b0, ready_o}, 32'd1);
    chk("bp_release_valid", {31'b0, valid_o}, 32'd0);
    chk("bp_release_sum", {16'b0, sum_o}, 32'h0123);

    // Reset after the second nibble of a run.
    a_i = 16'h4321; b_i = 16'h1111; carry_i = 1'b0; sub_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mrst_ready", {31'b0, ready_o}, 32'd1);
    chk("mrst_valid", {31'b0, valid_o}, 32'd0);
    chk("mrst_sum", {16'b0, sum_o}, 32'd0);
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit 200000");
    $fatal(1, "timeout");
  end

endmodule
